relu_act_unit: RTL and testbench
================================

# relu_act_unit

Parametrised multi-channel activation stage for the CNN layer pipeline, replacing the fixed per-layer ReLU blocks. It sits between a convolution/accumulate stage and pooling. Each accepted pixel carries one word per channel. The block applies a run-time-selected activation (ReLU, leaky ReLU, clipped ReLU, bypass), requantises by an arithmetic right shift, and saturates to the output width. It adds a valid/ready handshake with back-pressure and tracks frame position.

## Interface
- `IMAGE_WIDTH`, default 13: pixels per row.
- `IMAGE_HEIGHT`, default 17: rows per frame.
- `CHANNELS`, default 64: parallel channel words per pixel.
- `IN_BITS`, default 32: signed input word width.
- `OUT_BITS`, default 16: signed output word width; must be ≤ `IN_BITS`.
- `LEAK_SHIFT`, default 3: leaky slope is 2^-`LEAK_SHIFT`.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_mode`  in  2  activation select: 0 ReLU, 1 leaky, 2 clipped, 3 bypass.
- `cfg_shift`  in  5  requantisation right-shift amount, range 0..31.
- `cfg_clip`  in  IN_BITS  clipped-ReLU upper bound, taken as non-negative.
- `in_valid`  in  1  input pixel valid.
- `in_ready`  out  1  block can accept a pixel.
- `in_data`  in  CHANNELS×IN_BITS  unpacked array `[0:CHANNELS-1]` of signed words.
- `out_valid`  out  1  output pixel valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  CHANNELS×OUT_BITS  unpacked array of signed words.
- `out_last`  out  1  this output is the final pixel of a frame.
- `frame_cnt`  out  clog2(W·H)  count of accepted pixels in the current frame.

## Operation
- Accept: `in_valid && in_ready`. Emit: `out_valid && out_ready`.
- Config (`cfg_mode`, `cfg_shift`, `cfg_clip`) is latched into shadow registers on an accept when `frame_cnt == 0`. Config changes mid-frame take effect at the next frame only.
- Per-channel math uses signed arithmetic at IN_BITS+1 bits internally:
  - ReLU: `x > 0 ? x : 0`.
  - Leaky: `x ≥ 0 ? x : x >>> LEAK_SHIFT` (arithmetic shift, floor).
  - Clipped: `min(max(x, 0), cfg_clip)`.
  - Bypass: `x`.
- Requantise: arithmetic right shift by the latched shift amount (floor).
- Saturate to the signed OUT_BITS range [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
- `frame_cnt` increments on each accept. It wraps to 0 on the accept of pixel W·H-1.
- `out_last` is the frame-end tag of that pixel, carried through the pipeline alongside the data.

## Timing
- Two-stage pipeline:
  - S1 registers the activation result and `last` tag.
  - S2 registers the shifted, saturated result; S2 drives the outputs.
- Latency with `out_ready` held high: 2 cycles from accept to `out_valid`. Throughput is 1 pixel per cycle.
- Back-pressure:
  - Each stage advances when its downstream slot is empty or being emptied.
  - `in_ready = !s1_valid || (!s2_valid || out_ready)`, combinational.
  - No bubbles under continuous back-pressure release.
- While `out_valid && !out_ready`, `out_data` and `out_last` hold stable.
- Reset values:
  - `out_valid`, `out_last` = 0; `out_data` all 0; `frame_cnt` = 0.
  - Shadow config = ReLU, shift 0, clip 0.
  - `in_ready` = 1.
- Reset mid-frame: pipeline contents are discarded and `frame_cnt` returns to 0. The next accepted pixel starts a new frame.
- Simultaneous accept and emit in one cycle is a legal steady state.

## Structure
- Package `relu_pkg`: `act_mode_e` enum (`ACT_RELU`, `ACT_LEAKY`, `ACT_CLIP`, `ACT_BYPASS`) and a saturate function.
- Sub-module `relu_act_lane`: the combinational per-channel activation, shift and saturate math. It is instantiated CHANNELS times via generate. The top owns the pipeline registers, handshake, config shadow and frame counter.

## Test plan
- ReLU, shift 0, OUT_BITS=16, inputs {5, -7, 40000, 0} → outputs {5, 0, 32767, 0} two cycles after accept.
- Leaky, LEAK_SHIFT=3, shift 0, input -17 → output -3. With shift 1, input 9 → output 4.
- Clip with `cfg_clip`=100, inputs {250, 50, -1} → {100, 50, 0}. Switching `cfg_mode` mid-frame has no effect until the next frame's first pixel.
- Stream 221 pixels (13×17) → `out_last` is high only on output 221. `frame_cnt` wraps to 0 and a second frame repeats identically.
- Random `out_ready` toggling (≈50%) over 500 pixels → no loss or duplication, data stable while stalled, in-order outputs matching the model.
- Assert `rst_n` low with 2 pixels in flight → `out_valid` goes 0 immediately and `frame_cnt` goes 0. After release, `in_ready` is 1 and the first output has `out_last` 0.

Source files
------------

// File: rtl/relu_pkg.sv
// Shared types and helpers for the multi-channel activation stage.
package relu_pkg;

    typedef enum logic [1:0] {
        ACT_RELU   = 2'd0,
        ACT_LEAKY  = 2'd1,
        ACT_CLIP   = 2'd2,
        ACT_BYPASS = 2'd3
    } act_mode_e;

    // Working width for saturation; any IN_BITS + 1 up to this fits.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] v,
        input int                      out_bits
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = SAT_W'(1);
        hi  = (one <<< (out_bits - 1)) - one;
        lo  = -hi - one;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/relu_act_unit_if.sv
// Pixel stream into and out of the activation stage, one word per channel.
interface relu_act_unit_if #(
    parameter int CHANNELS = 64,
    parameter int IN_BITS  = 32,
    parameter int OUT_BITS = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [IN_BITS-1:0]  in_data  [CHANNELS];
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;
    logic signed [OUT_BITS-1:0] out_data [CHANNELS];

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/relu_act_lane.sv
// Per-channel math: activation (feeds S1) and requantise/saturate (feeds S2).
module relu_act_lane
    import relu_pkg::*;
#(
    parameter int IN_BITS    = 32,
    parameter int OUT_BITS   = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  act_mode_e                 mode,
    input  logic [IN_BITS-1:0]        clip,
    input  logic signed [IN_BITS-1:0] x,
    output logic signed [IN_BITS:0]   act,
    input  logic signed [IN_BITS:0]   act_q,
    input  logic [4:0]                shift,
    output logic signed [OUT_BITS-1:0] y
);
    logic signed [IN_BITS:0]  xe;
    logic signed [IN_BITS:0]  ce;
    logic signed [IN_BITS:0]  shifted;
    logic signed [SAT_W-1:0]  wide;

    assign xe = (IN_BITS + 1)'(x);
    assign ce = $signed({1'b0, clip});

    always_comb begin
        // NOTE: default assigned first so no path leaves act unassigned (no latch).
        act = xe;
        unique case (mode)
            ACT_RELU:   act = xe[IN_BITS] ? '0 : xe;
            ACT_LEAKY:  act = xe[IN_BITS] ? (xe >>> LEAK_SHIFT) : xe;
            ACT_CLIP:   act = xe[IN_BITS] ? '0 : ((xe > ce) ? ce : xe);
            ACT_BYPASS: act = xe;
        endcase
    end

    assign shifted = act_q >>> shift;
    assign wide    = SAT_W'(shifted);
    assign y       = OUT_BITS'(saturate(wide, OUT_BITS));

endmodule

// File: rtl/relu_act_unit.sv
// Two-stage activation pipeline with valid/ready back-pressure, config shadow
// latched at frame start, and frame position tracking.
module relu_act_unit
    import relu_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 13,
    parameter int IMAGE_HEIGHT = 17,
    parameter int CHANNELS     = 64,
    parameter int IN_BITS      = 32,
    parameter int OUT_BITS     = 16,
    parameter int LEAK_SHIFT   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          cfg_mode,
    input  logic [4:0]          cfg_shift,
    input  logic [IN_BITS-1:0]  cfg_clip,
    relu_act_unit_if.slave      bus,
    output logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT)-1:0] frame_cnt
);
    localparam int PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CNT_W  = $clog2(PIXELS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS - 1);

    act_mode_e                  sh_mode, eff_mode;
    logic [4:0]                 sh_shift, eff_shift;
    logic [IN_BITS-1:0]         sh_clip, eff_clip;

    logic                       s1_valid, s1_last;
    logic [4:0]                 s1_shift;
    logic signed [IN_BITS:0]    s1_act  [CHANNELS];
    logic                       s2_valid, s2_last;
    logic signed [OUT_BITS-1:0] s2_data [CHANNELS];

    logic signed [IN_BITS:0]    act_d   [CHANNELS];
    logic signed [OUT_BITS-1:0] sat_d   [CHANNELS];

    logic s1_free, s2_free, accept, frame_start, frame_end;

    assign s2_free      = !s2_valid || bus.out_ready;
    assign s1_free      = !s1_valid || s2_free;
    assign bus.in_ready = s1_free;
    assign accept       = bus.in_valid && s1_free;
    assign frame_start  = (frame_cnt == '0);
    assign frame_end    = (frame_cnt == LAST_IDX);

    // The first pixel of a frame already uses the config it is latching.
    assign eff_mode  = frame_start ? act_mode_e'(cfg_mode) : sh_mode;
    assign eff_shift = frame_start ? cfg_shift : sh_shift;
    assign eff_clip  = frame_start ? cfg_clip  : sh_clip;

    assign bus.out_valid = s2_valid;
    assign bus.out_last  = s2_last;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        relu_act_lane #(
            .IN_BITS   (IN_BITS),
            .OUT_BITS  (OUT_BITS),
            .LEAK_SHIFT(LEAK_SHIFT)
        ) u_lane (
            .mode (eff_mode),
            .clip (eff_clip),
            .x    (bus.in_data[i]),
            .act  (act_d[i]),
            .act_q(s1_act[i]),
            .shift(s1_shift),
            .y    (sat_d[i])
        );
        assign bus.out_data[i] = s2_data[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            sh_mode   <= ACT_RELU;
            sh_shift  <= '0;
            sh_clip   <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_shift  <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if (accept) begin
                frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
                s1_last   <= frame_end;
                s1_shift  <= eff_shift;
                if (frame_start) begin
                    sh_mode  <= act_mode_e'(cfg_mode);
                    sh_shift <= cfg_shift;
                    sh_clip  <= cfg_clip;
                end
            end
            if (s1_free) s1_valid <= accept;
            if (s2_free) begin
                s2_valid <= s1_valid;
                s2_last  <= s1_valid && s1_last;
            end
        end
    end

    // NOTE: S1 data is qualified by s1_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) s1_act <= act_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) s2_data[i] <= '0;
        end else if (s2_free && s1_valid) begin
            s2_data <= sat_d;
        end
    end

endmodule

// File: tb/tb_relu_act_unit.sv
// Scoreboard bench for relu_act_unit: directed frames plus random back-pressure.
module tb_relu_act_unit;
    localparam int W   = 13;
    localparam int H   = 17;
    localparam int CH  = 4;
    localparam int IB  = 32;
    localparam int OB  = 16;
    localparam int LS  = 3;
    localparam int PIX = W * H;

    typedef logic [CH-1:0][IB-1:0] pix_t;
    typedef struct packed {
        logic                  last;
        logic [CH-1:0][OB-1:0] d;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [1:0]             cfg_mode = 2'd0;
    logic [4:0]             cfg_shift = 5'd0;
    logic [IB-1:0]          cfg_clip = '0;
    logic [$clog2(PIX)-1:0] frame_cnt;

    relu_act_unit_if #(.CHANNELS(CH), .IN_BITS(IB), .OUT_BITS(OB)) bus ();

    relu_act_unit #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CHANNELS(CH),
        .IN_BITS(IB), .OUT_BITS(OB), .LEAK_SHIFT(LS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_mode (cfg_mode),
        .cfg_shift(cfg_shift),
        .cfg_clip (cfg_clip),
        .bus      (bus),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    exp_t   sb[$];
    int     tb_pos = 0;
    int     m_mode = 0;
    int     m_shift = 0;
    longint m_clip = 0;
    bit     held_pending = 1'b0;
    exp_t   held;
    int     num_last = 0;
    int     stalls = 0;

    function automatic longint model(input int mode, input int shift, input longint clip,
                                     input longint x);
        longint a, r;
        case (mode)
            0:       a = (x > 0) ? x : 0;
            1:       a = (x >= 0) ? x : (x >>> LS);
            2:       a = (x < 0) ? 0 : ((x > clip) ? clip : x);
            default: a = x;
        endcase
        r = a >>> shift;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic pix_t mk(input int a, input int b, input int c, input int d);
        pix_t p;
        p[0] = a; p[1] = b; p[2] = c; p[3] = d;
        return p;
    endfunction

    function automatic logic [IB-1:0] rnd_word();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return IB'($urandom_range(0, 400)) - 32'd200;
            2:       return IB'($urandom_range(0, 2000000)) - 32'd1000000;
            default: return IB'($urandom_range(0, 300000)) - 32'd150000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at negedge+1, score, then advance to the next negedge.
    task automatic tick(output bit acc);
        exp_t e, cur;
        #1;
        acc = bus.in_valid && bus.in_ready;
        check("frame_cnt", 64'(frame_cnt), 64'(tb_pos));
        cur.last = bus.out_last;
        for (int i = 0; i < CH; i++) cur.d[i] = $unsigned(bus.out_data[i]);
        if (held_pending) begin
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_data", cur.d, held.d);
            check("stall_last", 64'(cur.last), 64'(held.last));
        end
        if (bus.out_valid && bus.out_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", cur.d, e.d);
                check("out_last", 64'(cur.last), 64'(e.last));
                if (cur.last) num_last++;
            end
        end
        held_pending = bus.out_valid && !bus.out_ready;
        held = cur;
        if (acc) begin
            if (tb_pos == 0) begin
                m_mode  = int'(cfg_mode);
                m_shift = int'(cfg_shift);
                m_clip  = longint'({32'b0, cfg_clip});
            end
            e.last = (tb_pos == PIX - 1);
            for (int i = 0; i < CH; i++)
                e.d[i] = OB'(model(m_mode, m_shift, m_clip, longint'(bus.in_data[i])));
            sb.push_back(e);
            tb_pos = (tb_pos == PIX - 1) ? 0 : tb_pos + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_pixel(input pix_t px, input bit rnd);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        for (int i = 0; i < CH; i++) bus.in_data[i] = px[i];
        bus.in_valid = 1'b1;
        while (!acc && guard < 64) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            tick(acc);
            guard++;
            if (!acc) stalls++;
        end
        check("accept", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rest(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_shift = 5'($urandom_range(0, 6));
            cfg_clip  = IB'($urandom_range(0, 70000));
            send_pixel(rnd_word4(), rnd);
        end
    endtask

    function automatic pix_t rnd_word4();
        pix_t p;
        for (int i = 0; i < CH; i++) p[i] = rnd_word();
        return p;
    endfunction

    task automatic drain();
        bit acc;
        int guard;
        guard = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && guard < 50) begin
            tick(acc);
            guard++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        repeat (3) tick(acc);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < CH; i++) bus.in_data[i] = '0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        for (int i = 0; i < CH; i++) check("rst_out_data", 64'(bus.out_data[i]), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame A: ReLU, latency, mid-frame mode change, random back-pressure
        cfg_mode = 2'd0; cfg_shift = 5'd0; cfg_clip = '0;
        bus.out_ready = 1'b1;
        send_pixel(mk(5, -7, 40000, 0), 1'b0);
        check("lat_s1_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_s2_valid", 64'(bus.out_valid), 64'd1);
        check("relu_pos", 64'($unsigned(bus.out_data[0])), 64'd5);
        check("relu_neg", 64'($unsigned(bus.out_data[1])), 64'd0);
        check("relu_sat", 64'($unsigned(bus.out_data[2])), 64'd32767);
        check("relu_zero", 64'($unsigned(bus.out_data[3])), 64'd0);
        cfg_mode = 2'd1;
        send_pixel(mk(-17, 9, -100, 100), 1'b0);
        send_rest(PIX - 2, 1'b1);

        // Frame B: leaky, steady out_ready, no bubbles
        cfg_mode = 2'd1; cfg_shift = 5'd0;
        bus.out_ready = 1'b1;
        stalls = 0;
        send_pixel(mk(-17, 17, -8, -1), 1'b0);
        send_rest(PIX - 1, 1'b0);
        check("no_bubble_stalls", 64'(stalls), 64'd0);

        // Frame C: leaky with shift 1
        cfg_mode = 2'd1; cfg_shift = 5'd1;
        send_pixel(mk(9, -17, 1, -2), 1'b1);
        send_rest(PIX - 1, 1'b1);

        // Frame D: clipped at 100, switch to bypass mid-frame
        cfg_mode = 2'd2; cfg_shift = 5'd0; cfg_clip = 32'd100;
        send_pixel(mk(250, 50, -1, 100), 1'b1);
        cfg_mode = 2'd3;
        send_pixel(mk(250, -5, 101, 40000), 1'b1);
        send_rest(PIX - 2, 1'b1);
        drain();
        check("frames_last_count", 64'(num_last), 64'd4);
        check("frame_cnt_wrapped", 64'(frame_cnt), 64'd0);

        // Reset with two pixels in flight
        bus.out_ready = 1'b0;
        send_pixel(mk(1, 2, 3, 4), 1'b0);
        send_pixel(mk(5, 6, 7, 8), 1'b0);
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        check("pre_rst_cnt", 64'(frame_cnt), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("midrst_out_last", 64'(bus.out_last), 64'd0);
        sb.delete();
        tb_pos = 0;
        held_pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_in_ready", 64'(bus.in_ready), 64'd1);
        cfg_mode = 2'd0; cfg_shift = 5'd0;
        bus.out_ready = 1'b1;
        send_pixel(mk(-3, 3, 0, 70000), 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
